// File: rtl/wb_trace_pkg.sv
// Shared types and entry layout for the write-back trace buffer.
// WB_TRACE_TIMESTAMP_EN widens each entry with a 32-bit capture timestamp.
package wb_trace_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 4;
   localparam int DATA_LSB = 0;
   localparam int ADDR_LSB = 32;
   localparam int PORT_BIT = 36;
   localparam int BASE_W   = 37;
   localparam int TS_W     = 32;
   localparam int TS_LSB   = 37;
   localparam int DROP_W   = 16;
`ifdef WB_TRACE_TIMESTAMP_EN
   localparam int ENTRY_W  = BASE_W + TS_W;
`else
   localparam int ENTRY_W  = BASE_W;
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_STOPPED = 2'd2
   } state_e;
endpackage

// File: rtl/wb_trace_if.sv
// Register-file write ports observed by the trace buffer, plus the trace read port.
// Read handshake: an entry transfers on a rising edge with rd_valid && rd_ready; rd_valid never depends on rd_ready and rd_data holds while stalled.
interface wb_trace_if;
   import wb_trace_pkg::*;
   logic [1:0]         RegWriteW;
   logic [3:0]         wa3;
   logic [31:0]        wd3;
   logic [3:0]         wa3_2;
   logic [31:0]        wd3_2;
   logic               rd_valid;
   logic               rd_ready;
   logic [ENTRY_W-1:0] rd_data;

   modport master (output RegWriteW, wa3, wd3, wa3_2, wd3_2, rd_ready,
                   input  rd_valid, rd_data);
   modport slave  (input  RegWriteW, wa3, wd3, wa3_2, wd3_2, rd_ready,
                   output rd_valid, rd_data);
endinterface

// File: rtl/wb_trace_fifo.sv
// Circular buffer with two ordered write ports and one read port.
// Room is judged on occupancy before the same-cycle pop; accepted pushes are reported back.
module wb_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 37
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push0,
   input  logic                     push1,
   input  logic [W-1:0]             din0,
   input  logic [W-1:0]             din1,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     acc0,
   output logic                     acc1
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, wr_nx;
   logic [CW-1:0] cnt_q, cnt_d, free;
   logic          do_pop;

   always_comb begin
      free   = CW'(DEPTH) - cnt_q;
      acc0   = push0 && (free != '0);
      acc1   = push1 && (push0 ? (free >= CW'(2)) : (free != '0));
      do_pop = pop && (cnt_q != '0);
      wr_nx  = wr_q + PW'(1);
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      if (clear) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (acc0) mem_d[wr_q] = din0;
         // Port 2 lands behind port 1 when both are accepted.
         if (acc1) mem_d[acc0 ? wr_nx : wr_q] = din1;
         wr_d  = wr_q + PW'(acc0) + PW'(acc1);
         rd_d  = rd_q + PW'(do_pop);
         cnt_d = cnt_q + CW'(acc0) + CW'(acc1) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign dout  = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: session FSM, watch/post-count stop, drop counter, FIFO.
// WB_TRACE_TIMESTAMP_EN adds a free-running cycle counter stored with each entry.
module wb_trace_buffer
   import wb_trace_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int WATCH_REG   = 0,
   parameter int POST_WRITES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic [31:0]            watch_val,
   wb_trace_if.slave              wb,
   output logic [$clog2(DEPTH):0] count,
   output logic [DROP_W-1:0]      drop_cnt,
   output logic                   hit,
   output logic [1:0]             state,
   output logic                   done
);
   localparam logic [3:0] WREG      = 4'(WATCH_REG);
   localparam logic [7:0] POST_INIT = 8'(POST_WRITES);

   state_e              state_q, state_d;
   logic                hit_q, hit_d;
   logic [7:0]          post_q, post_d;
   logic [DROP_W-1:0]   drop_q, drop_d;
   logic [DROP_W:0]     drop_sum;
   logic                do_start, en0, en1, hit0, hit1, acc0, acc1, exhaust;
   logic [1:0]          n_wr, n_drop;
   logic [ENTRY_W-1:0]  ent0, ent1;

`ifdef WB_TRACE_TIMESTAMP_EN
   logic [31:0] ts_q, ts_d;
   always_comb ts_d = ts_q + 32'd1;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_d;
   end
   assign ent0 = {ts_q, 1'b0, wb.wa3,   wb.wd3};
   assign ent1 = {ts_q, 1'b1, wb.wa3_2, wb.wd3_2};
`else
   assign ent0 = {1'b0, wb.wa3,   wb.wd3};
   assign ent1 = {1'b1, wb.wa3_2, wb.wd3_2};
`endif

   // Start (without stop) clears the session, so its own cycle's writes are not recorded.
   assign do_start = start && !stop;
   assign en0      = wb.RegWriteW[0] && (state_q == ST_CAPTURE) && !do_start;
   assign en1      = wb.RegWriteW[1] && (state_q == ST_CAPTURE) && !do_start;
   assign hit0     = en0 && (wb.wa3   == WREG) && (wb.wd3   == watch_val);
   assign hit1     = en1 && (wb.wa3_2 == WREG) && (wb.wd3_2 == watch_val);
   assign n_wr     = {1'b0, en0} + {1'b0, en1};
   assign n_drop   = {1'b0, en0 && !acc0} + {1'b0, en1 && !acc1};
   assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);

   wb_trace_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (do_start),
      .push0 (en0),
      .push1 (en1),
      .din0  (ent0),
      .din1  (ent1),
      .pop   (wb.rd_ready),
      .dout  (wb.rd_data),
      .count (count),
      .acc0  (acc0),
      .acc1  (acc1)
   );

   always_comb begin
      state_d = state_q;
      hit_d   = hit_q;
      post_d  = post_q;
      drop_d  = drop_q;
      exhaust = 1'b0;
      if (do_start) begin
         hit_d  = 1'b0;
         post_d = '0;
         drop_d = '0;
      end else if (state_q == ST_CAPTURE) begin
         drop_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
         if (!hit_q) begin
            if (hit0 || hit1) begin
               hit_d   = 1'b1;
               post_d  = POST_INIT;
               exhaust = (POST_INIT == 8'd0);
            end
         end else begin
            post_d  = (post_q > {6'd0, n_wr}) ? post_q - {6'd0, n_wr} : 8'd0;
            exhaust = (post_d == 8'd0);
         end
      end
      if (stop)         state_d = ST_STOPPED;
      else if (start)   state_d = ST_CAPTURE;
      else if (exhaust) state_d = ST_STOPPED;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         hit_q   <= 1'b0;
         post_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         post_q  <= post_d;
         drop_q  <= drop_d;
      end
   end

   assign wb.rd_valid = (count != '0);
   assign drop_cnt    = drop_q;
   assign hit         = hit_q;
   assign state       = state_q;
   assign done        = (state_q == ST_STOPPED) && (count == '0);
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: queue-based session model plus directed literal checks.
module tb_wb_trace_buffer;
   import wb_trace_pkg::*;

   localparam int DEPTH = 16;
   localparam int WREG  = 0;
   localparam int POST  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] watch_val = '0;
   logic [4:0]  count;
   logic [15:0] drop_cnt;
   logic        hit;
   logic [1:0]  state;
   logic        done;
   int          n_checks = 0;
   int          n_fail = 0;

   wb_trace_if bus();

   wb_trace_buffer #(.DEPTH(DEPTH), .WATCH_REG(WREG), .POST_WRITES(POST)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .watch_val (watch_val),
      .wb        (bus),
      .count     (count),
      .drop_cnt  (drop_cnt),
      .hit       (hit),
      .state     (state),
      .done      (done)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [ENTRY_W-1:0] exp_q[$];
   logic [ENTRY_W-1:0] w_q[$];
   int                 m_state, m_post, m_drop, m_free, m_nw;
   bit                 m_hit, m_ds, m_pop, m_any_hit, m_stop_now;
   logic [31:0]        m_ts;

   function automatic logic [ENTRY_W-1:0] mk_entry(input logic p, input logic [3:0] a,
                                                   input logic [31:0] d);
`ifdef WB_TRACE_TIMESTAMP_EN
      return {m_ts, p, a, d};
`else
      return {p, a, d};
`endif
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         m_state = 0; m_post = 0; m_drop = 0; m_hit = 0; m_ts = '0;
      end else begin
         m_ds       = start && !stop;
         m_pop      = (exp_q.size() != 0) && bus.rd_ready;
         m_free     = DEPTH - exp_q.size();
         m_stop_now = 0;
         if (m_pop) void'(exp_q.pop_front());
         if (m_ds) begin
            exp_q.delete();
            m_hit = 0; m_post = 0; m_drop = 0;
         end else if (m_state == 1) begin
            w_q.delete();
            m_any_hit = 0;
            m_nw = 0;
            if (bus.RegWriteW[0]) begin
               w_q.push_back(mk_entry(1'b0, bus.wa3, bus.wd3));
               m_nw++;
               if (bus.wa3 == WREG && bus.wd3 == watch_val) m_any_hit = 1;
            end
            if (bus.RegWriteW[1]) begin
               w_q.push_back(mk_entry(1'b1, bus.wa3_2, bus.wd3_2));
               m_nw++;
               if (bus.wa3_2 == WREG && bus.wd3_2 == watch_val) m_any_hit = 1;
            end
            foreach (w_q[i]) begin
               if (i < m_free) exp_q.push_back(w_q[i]);
               else if (m_drop < 65535) m_drop++;
            end
            if (m_hit) begin
               m_post     = (m_post > m_nw) ? m_post - m_nw : 0;
               m_stop_now = (m_post == 0);
            end else if (m_any_hit) begin
               m_hit      = 1;
               m_post     = POST;
               m_stop_now = (POST == 0);
            end
         end
         if (stop)            m_state = 2;
         else if (start)      m_state = 1;
         else if (m_stop_now) m_state = 2;
         m_ts = m_ts + 32'd1;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [ENTRY_W-1:0] exp_head;
   always @(negedge clk) begin
      if (!reset) begin
         exp_head = '0;
         if (exp_q.size() != 0) exp_head = exp_q[0];
         check("rd_valid", bus.rd_valid, exp_q.size() != 0);
         check("rd_data",  bus.rd_data,  exp_head);
         check("count",    count,        exp_q.size());
         check("drop_cnt", drop_cnt,     m_drop);
         check("hit",      hit,          m_hit);
         check("state",    state,        m_state);
         check("done",     done,         (m_state == 2) && (exp_q.size() == 0));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic quiet();
      start = 1'b0;
      stop  = 1'b0;
      bus.RegWriteW = 2'b00;
      bus.rd_ready  = 1'b0;
   endtask

   task automatic wr(input logic [1:0] we, input logic [3:0] a1, input logic [31:0] d1,
                     input logic [3:0] a2, input logic [31:0] d2);
      bus.RegWriteW = we;
      bus.wa3   = a1;
      bus.wd3   = d1;
      bus.wa3_2 = a2;
      bus.wd3_2 = d2;
   endtask

   task automatic pulse_start();
      quiet();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int rdy_pct;

   initial begin
      quiet();
      wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      watch_val = 32'd10;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("reset_state",    state,        2'd0);
      check("reset_count",    count,        5'd0);
      check("reset_rd_valid", bus.rd_valid, 1'b0);
      check("reset_rd_data",  bus.rd_data,  '0);
      check("reset_hit",      hit,          1'b0);
      check("reset_drop",     drop_cnt,     16'd0);
      check("reset_done",     done,         1'b0);

      // basic single write
      pulse_start();
      check("start_state", state, 2'd1);
      wr(2'b01, 4'd2, 32'd7, 4'd0, 32'd0);
      tick();
      wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check("basic_valid", bus.rd_valid, 1'b1);
      check("basic_data",  bus.rd_data[36:0], 37'h2_0000_0007);
      check("basic_count", count, 5'd1);
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      check("basic_pop_count", count, 5'd0);

      // dual write, port order
      wr(2'b11, 4'd0, 32'h11, 4'd1, 32'h22);
      tick();
      wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check("dual_count", count, 5'd2);
      check("dual_head0", bus.rd_data[36:0], 37'h00_0000_0011);
      bus.rd_ready = 1'b1;
      tick();
      check("dual_head1", bus.rd_data[36:0], 37'h11_0000_0022);
      tick();
      bus.rd_ready = 1'b0;
      check("dual_empty", count, 5'd0);

      // overflow: 15 entries then a dual write, then a write into a full FIFO
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         wr(2'b01, 4'd3, 32'(i), 4'd0, 32'd0);
         tick();
      end
      wr(2'b11, 4'd4, 32'h44, 4'd5, 32'h55);
      tick();
      check("ovf_count", count, 5'd16);
      check("ovf_drop",  drop_cnt, 16'd1);
      wr(2'b01, 4'd6, 32'h66, 4'd0, 32'd0);
      bus.rd_ready = 1'b1;
      tick();
      wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check("full_pop_count", count, 5'd15);
      check("full_drop",      drop_cnt, 16'd2);
      repeat (15) tick();
      bus.rd_ready = 1'b0;
      check("ovf_drained", count, 5'd0);

      // stop, then start alone clears drop counter
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_state", state, 2'd2);
      check("stop_done",  done, 1'b1);
      pulse_start();
      check("restart_state", state, 2'd1);
      check("restart_drop",  drop_cnt, 16'd0);

      // watch and post-write stop
      wr(2'b01, 4'd0, 32'd10, 4'd0, 32'd0);
      tick();
      check("watch_hit",   hit, 1'b1);
      check("watch_state", state, 2'd1);
      for (int i = 0; i < 3; i++) begin
         wr(2'b01, 4'd7, 32'(100 + i), 4'd0, 32'd0);
         tick();
      end
      wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check("watch_count", count, 5'd3);
      check("watch_stop",  state, 2'd2);
      check("watch_drop",  drop_cnt, 16'd0);
      bus.rd_ready = 1'b1;
      repeat (3) tick();
      bus.rd_ready = 1'b0;
      check("watch_done", done, 1'b1);
      pulse_start();
      check("restart_hit", hit, 1'b0);

      // start+stop together in IDLE
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      quiet();
      check("prio_state", state, 2'd2);
      pulse_start();
      check("prio_capture", state, 2'd1);

      // asynchronous reset mid-capture
      for (int i = 0; i < 5; i++) begin
         wr(2'b01, 4'd9, 32'(i), 4'd0, 32'd0);
         tick();
      end
      wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check("pre_reset_count", count, 5'd5);
      #2 reset = 1'b1;
      #1;
      check("async_count", count, 5'd0);
      check("async_valid", bus.rd_valid, 1'b0);
      check("async_state", state, 2'd0);
      tick();
      reset = 1'b0;

      // randomized sessions
      rdy_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) rdy_pct = $urandom_range(0, 100);
         start = ($urandom_range(0, 29) == 0);
         stop  = ($urandom_range(0, 99) == 0);
         if (start) watch_val = 32'($urandom_range(0, 3));
         wr(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
         bus.rd_ready = ($urandom_range(0, 99) < rdy_pct);
         tick();
      end
      quiet();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Synthesizable write-back trace buffer that sits directly downstream of the processor's register-file write ports (write-back stage). It records every register write (both ports, including the second port used by long multiplication) into a FIFO. It detects a configurable "watch" write, such as R0 receiving its final value, and stops capture a fixed number of writes later. A bench or debug host drains entries through a valid/ready port.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥4.
- WATCH_REG, 0: register index (0–15) compared for the watch event.
- POST_WRITES, 4: write events still captured after the hit cycle before stopping; 0–255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a new capture session.
- stop  in  1  force end of capture.
- watch_val  in  32  value compared against writes to WATCH_REG.
- RegWriteW  in  2  bit0 enables port 1, bit1 enables port 2.
- wa3  in  4  port-1 register address.
- wd3  in  32  port-1 data.
- wa3_2  in  4  port-2 register address.
- wd3_2  in  32  port-2 data.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head entry.
- rd_data  out  37 (69 with timestamp)  entry layout: [36] port (0 = port 1), [35:32] address, [31:0] data, [68:37] timestamp.
- count  out  $clog2(DEPTH)+1  occupied entries.
- drop_cnt  out  16  saturating count of writes lost to a full FIFO.
- hit  out  1  sticky watch-hit flag.
- state  out  2  IDLE=0, CAPTURE=1, STOPPED=2.
- done  out  1  state==STOPPED and count==0.

## Operation
- Reset values: state=IDLE, FIFO empty, count=0, drop_cnt=0, hit=0, rd_valid=0, rd_data=0, done=0, post counter=0.
- FSM transitions:
  - IDLE→CAPTURE on start.
  - STOPPED→CAPTURE on start.
  - CAPTURE→STOPPED on stop.
  - CAPTURE→STOPPED when the post counter is exhausted.
  - IDLE→STOPPED on stop.
  - stop wins over start in the same cycle.
  - start in CAPTURE restarts the session.
- Start actions: start (any state, without stop) clears the FIFO, hit, drop_cnt and the post counter. Writes in the start cycle are not captured.
- Capture rules:
  - Writes are captured only in CAPTURE.
  - Writes in IDLE or STOPPED are ignored and not counted as drops.
  - Up to 2 pushes per cycle. Port 1 is enqueued before port 2.
  - Same-address writes on both ports produce two entries.
- Full handling: free slots = DEPTH − count, sampled before the same-cycle pop; a pop does not create room in that cycle. If one slot is free and two writes arrive, port 1 is stored, port 2 is dropped, and drop_cnt is incremented. drop_cnt saturates at 0xFFFF.
- Watch:
  - A hit is a CAPTURE-state write (either port, enabled) with address == WATCH_REG and data == watch_val.
  - On the first hit, hit is set and the post counter loads POST_WRITES.
  - In each later cycle, the counter decrements by the number of enabled writes, flooring at 0.
  - All writes of the cycle that reaches 0 are still captured. The state then becomes STOPPED at the next edge.
  - With POST_WRITES=0, the FSM stops at the edge after the hit cycle, and the hit cycle's writes are captured.
  - Further hits do not reload the counter.
- Read side:
  - rd_valid = count≠0.
  - rd_data is the head entry, or 0 when empty.
  - A pop occurs when rd_valid && rd_ready.
  - rd_ready while empty has no effect.
- Reset mid-session returns everything to reset values immediately; contents are lost.

## Timing
- A write sampled at edge N is visible on rd_data/rd_valid after edge N (zero-cycle bubble, registered storage).
- Pop at edge N: the next entry appears after edge N.
- count, drop_cnt, hit and state all update at the same edge as the event.
- done is combinational from the registered state and count.
- Throughput: sustained 1 pop per cycle; burst of 2 pushes per cycle.

## Configuration
- WB_TRACE_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter runs from reset (reset value 0, increments every cycle, wraps at 2^32).
  - Its value at the capture edge is stored in rd_data[68:37].
  - rd_data is 69 bits.
- WB_TRACE_TIMESTAMP_EN undefined:
  - No counter exists.
  - rd_data is 37 bits.
  - Behaviour is otherwise identical.

## Structure
- Shared package wb_trace_pkg contains:
  - entry field widths and offsets;
  - entry width, depending on the macro;
  - state encodings IDLE/CAPTURE/STOPPED;
  - DROP_W=16.
- Sub-module wb_trace_fifo is a circular buffer with 2 write ports and 1 read port. It has wrapping pointers, an occupancy counter, and push-acceptance logic, and reports accepted pushes back.
- The FSM, watch logic, drop counter and timestamp live in wb_trace_buffer.

## Test plan
- Basic write: reset, start, then a port-1 write R2=7 → one cycle later rd_valid=1, rd_data={0,2,7}, count=1. Pop → count=0.
- Dual write: long-multiply write R0=0x11, R1=0x22 in one cycle → two entries in port order: {0,0,0x11}, then {1,1,0x22}.
- Overflow: DEPTH=16; fill to 15 with rd_ready=0, then a dual write → count=16, drop_cnt=1, port-2 entry absent.
- Watch and stop: WATCH_REG=0, watch_val=10, POST_WRITES=2.
  - Write R0=10, then single writes in 3 further cycles.
  - Expected: hit=1; exactly 3 entries are captured (the hit entry and 2 post writes); state=STOPPED; the third post write is ignored; drop_cnt=0.
  - After draining, done=1.
- Control priority: start and stop asserted together in IDLE → STOPPED. Then start alone → CAPTURE with FIFO, hit and drop_cnt cleared.
- Reset mid-capture: 5 entries queued, then assert reset asynchronously between edges → count=0, rd_valid=0, state=IDLE immediately.
